vending_machine_param: RTL and testbench

Parametrised successor to the fixed-price, 2-state-credit vending FSM. It accumulates coin credit up to a configurable price and issues a one-cycle dispense pulse. Overpayment and cancelled credit are returned as a greedy multi-cycle change payout, and a stock counter provides a sold-out lockout with restock. It sits between the coin acceptor front end and the dispense/change actuator drivers.

---
 rtl/vending_machine_param.sv | 117 +++++++++++
 tb/tb_vending_machine_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// Parametrised coin-credit vending controller: accumulates credit up to PRICE,
// pulses a dispense, pays change greedily, and tracks stock for sold-out lockout.
//
// state  | meaning
// IDLE   | no credit held
// CREDIT | 0 < credit < PRICE, accepting coins
// VEND   | one-cycle dispense pulse
// CHANGE | paying out remaining credit one coin per cycle
module vending_machine_param #(
  parameter int CREDIT_W   = 4,
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 12,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                restock,
  output logic                out,
  output logic [1:0]          change,
  output logic                change_valid,
  output logic                coin_reject,
  output logic                busy,
  output logic                sold_out,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0] MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [STOCK_W-1:0]  stock, stock_nxt;
  logic [CREDIT_W:0]   sum, rem;
  logic                coin_present, can_accept;

  function automatic logic [2:0] value_of(input logic [1:0] c);
    case (c)
      2'b01:   return 3'd1;
      2'b10:   return 3'd2;
      2'b11:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Largest coin not exceeding the given credit.
  function automatic logic [1:0] greedy_code(input logic [CREDIT_W-1:0] c);
    logic [CREDIT_W:0] ce;
    ce = {1'b0, c};
    if (ce >= (CREDIT_W+1)'(4))      return 2'b11;
    else if (ce >= (CREDIT_W+1)'(2)) return 2'b10;
    else                             return 2'b01;
  endfunction

  always_comb begin
    coin_present = coin_valid && (coin != 2'b00);
    sum          = {1'b0, credit} + (CREDIT_W+1)'(value_of(coin));
    rem          = {1'b0, credit} - PRICE_X;
    can_accept   = coin_present && !sold_out && !cancel &&
                   ((state == IDLE) || (state == CREDIT)) && (sum <= MAX_X);
    state_nxt    = state;
    credit_nxt   = credit;
    stock_nxt    = stock;
    case (state)
      IDLE, CREDIT: begin
        if ((state == CREDIT) && cancel) begin
          state_nxt = CHANGE;
        end else if (can_accept) begin
          credit_nxt = sum[CREDIT_W-1:0];
          state_nxt  = (sum >= PRICE_X) ? VEND : CREDIT;
        end
        if ((state == IDLE) && restock) stock_nxt = STOCK_W'(STOCK_INIT);
      end
      VEND: begin
        credit_nxt = rem[CREDIT_W-1:0];
        stock_nxt  = stock - STOCK_W'(1);
        state_nxt  = (rem != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        credit_nxt = credit - CREDIT_W'(value_of(greedy_code(credit)));
        state_nxt  = (credit_nxt == '0) ? IDLE : CHANGE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      credit       <= '0;
      stock        <= STOCK_W'(STOCK_INIT);
      out          <= 1'b0;
      change       <= 2'b00;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
      sold_out     <= (STOCK_INIT == 0);
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      stock        <= stock_nxt;
      out          <= (state_nxt == VEND);
      change_valid <= (state_nxt == CHANGE);
      change       <= (state_nxt == CHANGE) ? greedy_code(credit_nxt) : 2'b00;
      coin_reject  <= coin_present && !can_accept;
      busy         <= (state_nxt == VEND) || (state_nxt == CHANGE);
      sold_out     <= (stock_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: three parameterisations share a clock;
// stimulus queues expected output events, a monitor pops and compares them.
module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid_s [3];
  logic [1:0] coin_s       [3];
  logic       cancel_s     [3];
  logic       restock_s    [3];
  logic       out_s        [3];
  logic [1:0] change_s     [3];
  logic       cv_s         [3];
  logic       rej_s        [3];
  logic       busy_s       [3];
  logic       sold_s       [3];
  logic [3:0] credit_s     [3];

  logic [4:0] exp_q [3][$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // a: defaults; b: PRICE=1, STOCK_INIT=2; c: PRICE=12 to reach the MAX_CREDIT edge
  vending_machine_param dut_a (
    .clk(clk), .rst(rst), .coin_valid(coin_valid_s[0]), .coin(coin_s[0]),
    .cancel(cancel_s[0]), .restock(restock_s[0]), .out(out_s[0]), .change(change_s[0]),
    .change_valid(cv_s[0]), .coin_reject(rej_s[0]), .busy(busy_s[0]),
    .sold_out(sold_s[0]), .credit(credit_s[0]));

  vending_machine_param #(.PRICE(1), .STOCK_INIT(2)) dut_b (
    .clk(clk), .rst(rst), .coin_valid(coin_valid_s[1]), .coin(coin_s[1]),
    .cancel(cancel_s[1]), .restock(restock_s[1]), .out(out_s[1]), .change(change_s[1]),
    .change_valid(cv_s[1]), .coin_reject(rej_s[1]), .busy(busy_s[1]),
    .sold_out(sold_s[1]), .credit(credit_s[1]));

  vending_machine_param #(.PRICE(12)) dut_c (
    .clk(clk), .rst(rst), .coin_valid(coin_valid_s[2]), .coin(coin_s[2]),
    .cancel(cancel_s[2]), .restock(restock_s[2]), .out(out_s[2]), .change(change_s[2]),
    .change_valid(cv_s[2]), .coin_reject(rej_s[2]), .busy(busy_s[2]),
    .sold_out(sold_s[2]), .credit(credit_s[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ev(input logic r, input logic o, input logic [1:0] c);
    return {r, o, (c != 2'b00), c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin_in(input int d, input logic [1:0] c);
    coin_valid_s[d] = 1'b1;
    coin_s[d]       = c;
    tick();
    coin_valid_s[d] = 1'b0;
    coin_s[d]       = 2'b00;
  endtask

  // Event word: {coin_reject, out, change_valid, change}
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rej_s[i] || out_s[i] || cv_s[i]) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("unexpected_event_dut%0d", i),
                {27'd0, rej_s[i], out_s[i], cv_s[i], change_s[i]}, 32'd0);
        end else begin
          logic [4:0] e;
          e = exp_q[i].pop_front();
          check($sformatf("event_dut%0d", i),
                {27'd0, rej_s[i], out_s[i], cv_s[i], change_s[i]}, {27'd0, e});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      coin_valid_s[i] = 1'b0;
      coin_s[i]       = 2'b00;
      cancel_s[i]     = 1'b0;
      restock_s[i]    = 1'b0;
    end
    tick();
    tick();
    check("rst_credit", credit_s[0], 0);
    check("rst_out", out_s[0], 0);
    check("rst_busy", busy_s[0], 0);
    check("rst_sold_out", sold_s[0], 0);
    check("rst_cv", cv_s[0], 0);
    rst = 1'b0;
    tick();

    // exact payment 1 + 2
    coin_in(0, 2'b01);
    check("t1_credit1", credit_s[0], 1);
    exp_q[0].push_back(ev(0, 1, 2'b00));
    coin_in(0, 2'b10);
    check("t1_busy_vend", busy_s[0], 1);
    tick();
    check("t1_credit0", credit_s[0], 0);
    check("t1_idle", busy_s[0], 0);
    check("t1_stock", dut_a.stock, 14);

    // zero coin code is ignored
    coin_in(0, 2'b00);
    check("t1_zero_coin_credit", credit_s[0], 0);

    // overpay 4 -> one 01 change coin
    exp_q[0].push_back(ev(0, 1, 2'b00));
    exp_q[0].push_back(ev(0, 0, 2'b01));
    coin_in(0, 2'b11);
    tick();
    check("t2_change_credit", credit_s[0], 1);
    tick();
    check("t2_credit0", credit_s[0], 0);
    check("t2_idle", busy_s[0], 0);

    // cancel wins over same-cycle coin
    coin_in(0, 2'b10);
    check("t4_credit2", credit_s[0], 2);
    exp_q[0].push_back(ev(1, 0, 2'b10));
    cancel_s[0] = 1'b1;
    coin_in(0, 2'b01);
    cancel_s[0] = 1'b0;
    tick();
    check("t4_credit0", credit_s[0], 0);

    // coin while busy is rejected
    exp_q[0].push_back(ev(0, 1, 2'b00));
    coin_in(0, 2'b11);
    check("t5_busy", busy_s[0], 1);
    exp_q[0].push_back(ev(1, 0, 2'b01));
    coin_in(0, 2'b01);
    check("t5_credit_unchanged", credit_s[0], 1);
    tick();
    check("t5_credit0", credit_s[0], 0);

    // MAX_CREDIT boundary on dut_c
    coin_in(2, 2'b11);
    coin_in(2, 2'b11);
    coin_in(2, 2'b10);
    check("max_credit10", credit_s[2], 10);
    exp_q[2].push_back(ev(1, 0, 2'b00));
    coin_in(2, 2'b11);
    check("max_reject_credit", credit_s[2], 10);
    exp_q[2].push_back(ev(0, 1, 2'b00));
    coin_in(2, 2'b10);
    check("max_exact_credit12", credit_s[2], 12);
    tick();
    check("max_credit0", credit_s[2], 0);

    // PRICE=1 greedy change 10, 01 then sold-out and restock on dut_b
    check("b_sold_out_init", sold_s[1], 0);
    exp_q[1].push_back(ev(0, 1, 2'b00));
    exp_q[1].push_back(ev(0, 0, 2'b10));
    exp_q[1].push_back(ev(0, 0, 2'b01));
    coin_in(1, 2'b11);
    tick();
    check("b_change_credit3", credit_s[1], 3);
    tick();
    tick();
    check("b_credit0", credit_s[1], 0);
    check("b_not_sold_out", sold_s[1], 0);
    exp_q[1].push_back(ev(0, 1, 2'b00));
    coin_in(1, 2'b01);
    tick();
    check("b_sold_out", sold_s[1], 1);
    exp_q[1].push_back(ev(1, 0, 2'b00));
    coin_in(1, 2'b01);
    check("b_soldout_credit", credit_s[1], 0);
    restock_s[1] = 1'b1;
    tick();
    restock_s[1] = 1'b0;
    check("b_restock_sold_out", sold_s[1], 0);
    check("b_restock_stock", dut_b.stock, 2);

    // async reset in the middle of a payout
    coin_in(0, 2'b10);
    exp_q[0].push_back(ev(0, 1, 2'b00));
    exp_q[0].push_back(ev(0, 0, 2'b10));
    coin_in(0, 2'b11);
    tick();
    check("rst_mid_cv_before", cv_s[0], 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_cv", cv_s[0], 0);
    check("rst_mid_change", change_s[0], 0);
    check("rst_mid_credit", credit_s[0], 0);
    check("rst_mid_busy", busy_s[0], 0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 3; i++)
      check($sformatf("queue_drained_dut%0d", i), exp_q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
